// File: rtl/per_multi_rst_clk_seq_pkg.sv
// ============================================================================
// Module : rcc_seq_pkg
// Brief  : State encodings and counter sizing for the RCC reset/clock sequencer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rcc_seq_pkg;

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_REL    = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_ASSERT = 2'd3;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/per_multi_rst_clk_seq_ch.sv
// ============================================================================
// Module : per_rst_clk_seq_ch
// Brief  : Single-channel reset/clock-enable sequencer FSM with optional
//          idle auto-gating (macro PER_AUTO_IDLE_GATE_EN)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module per_rst_clk_seq_ch
  import rcc_seq_pkg::*;
#(
  parameter int RST_CLK_CYCLES           = 4,
  parameter int CLK_ON_AFTER_RST_RELEASE = 2,
  parameter int IDLE_CYCLES              = 16
) (
  input  logic i_clk,
  input  logic sys_rst_n,
  input  logic en_req,
  input  logic rst_req,
  input  logic idle,
  output logic clk_en,
  output logic rst_n,
  output logic rdy,
  output logic busy
);

  localparam int            CW         = cnt_width(RST_CLK_CYCLES, CLK_ON_AFTER_RST_RELEASE,
                                                   IDLE_CYCLES);
  localparam logic [CW-1:0] C_RST_LOAD = CW'(RST_CLK_CYCLES);
  localparam logic [CW-1:0] C_REL_LOAD = CW'(CLK_ON_AFTER_RST_RELEASE);
  localparam logic [CW-1:0] C_ONE      = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_en_q, clk_en_d;
  logic          rst_n_q, rst_n_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic          idle_gate;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (!rst_req) begin
          if (C_REL_LOAD == '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_REL;
            cnt_d   = C_REL_LOAD;
          end
        end
      end
      ST_REL: begin
        // A new reset request wins over completing the release delay
        if (rst_req) begin
          state_d = ST_ASSERT;
          cnt_d   = C_RST_LOAD;
        end else if (cnt_q <= C_ONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - C_ONE;
        end
      end
      ST_RUN: begin
        if (rst_req) begin
          state_d = ST_ASSERT;
          cnt_d   = C_RST_LOAD;
        end
      end
      default: begin
        // ASSERT ignores rst_req so the reset width is never cut or extended
        if (cnt_q <= C_ONE) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - C_ONE;
        end
      end
    endcase
  end

`ifdef PER_AUTO_IDLE_GATE_EN
  localparam logic [CW-1:0] C_IDLE = CW'(IDLE_CYCLES);

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && en_req && idle) begin
      idle_cnt_d = (idle_cnt_q == C_IDLE) ? idle_cnt_q : idle_cnt_q + C_ONE;
    end
  end

  assign idle_gate = (idle_cnt_q == C_IDLE) && idle;

  always_ff @(posedge i_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_idle;
  assign unused_idle = idle;
  assign idle_gate   = 1'b0;
`endif

  // Outputs are decoded from the next state so they line up with the state flops
  always_comb begin
    clk_en_d = 1'b0;
    rst_n_d  = 1'b0;
    rdy_d    = 1'b0;
    busy_d   = 1'b0;
    case (state_d)
      ST_HOLD: ;
      ST_REL: begin
        rst_n_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_RUN: begin
        rst_n_d  = 1'b1;
        rdy_d    = 1'b1;
        clk_en_d = en_req & ~idle_gate;
      end
      default: begin
        clk_en_d = 1'b1;
        busy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign clk_en = clk_en_q;
  assign rst_n  = rst_n_q;
  assign rdy    = rdy_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: rtl/per_multi_rst_clk_seq.sv
// ============================================================================
// Module : per_multi_rst_clk_seq
// Brief  : N-channel RCC reset/clock-enable sequencer; optional idle
//          auto-gating via macro PER_AUTO_IDLE_GATE_EN
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module per_multi_rst_clk_seq
  import rcc_seq_pkg::*;
#(
  parameter int CH_NUM                   = 4,
  parameter int RST_CLK_CYCLES           = 4,
  parameter int CLK_ON_AFTER_RST_RELEASE = 2,
  parameter int IDLE_CYCLES              = 16
) (
  input  logic              i_clk,
  input  logic              sys_rst_n,
  input  logic [CH_NUM-1:0] ch_en_req,
  input  logic [CH_NUM-1:0] ch_rst_req,
  input  logic [CH_NUM-1:0] ch_idle,
  input  logic              testmode,
  output logic [CH_NUM-1:0] ch_clk_en,
  output logic [CH_NUM-1:0] ch_rst_n,
  output logic [CH_NUM-1:0] ch_rdy,
  output logic [CH_NUM-1:0] ch_busy
);

  logic [CH_NUM-1:0] clk_en_seq;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    per_rst_clk_seq_ch #(
      .RST_CLK_CYCLES          (RST_CLK_CYCLES),
      .CLK_ON_AFTER_RST_RELEASE(CLK_ON_AFTER_RST_RELEASE),
      .IDLE_CYCLES             (IDLE_CYCLES)
    ) u_ch (
      .i_clk    (i_clk),
      .sys_rst_n(sys_rst_n),
      .en_req   (ch_en_req[i]),
      .rst_req  (ch_rst_req[i]),
      .idle     (ch_idle[i]),
      .clk_en   (clk_en_seq[i]),
      .rst_n    (ch_rst_n[i]),
      .rdy      (ch_rdy[i]),
      .busy     (ch_busy[i])
    );
  end

  // testmode bypasses the sequencer on the gate enables only
  assign ch_clk_en = clk_en_seq | {CH_NUM{testmode}};

endmodule

`default_nettype wire

// File: tb/tb_per_multi_rst_clk_seq.sv
// ============================================================================
// Module : tb_per_multi_rst_clk_seq
// Brief  : Directed self-checking bench for per_multi_rst_clk_seq
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_per_multi_rst_clk_seq;

  logic       i_clk = 1'b0;
  logic       sys_rst_n;
  logic [3:0] ch_en_req, ch_rst_req, ch_idle;
  logic       testmode;
  logic [3:0] ch_clk_en, ch_rst_n, ch_rdy, ch_busy;

  logic [0:0] z_en_req, z_rst_req, z_idle;
  logic [0:0] z_clk_en, z_rst_n, z_rdy, z_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  per_multi_rst_clk_seq u_dut (
    .i_clk     (i_clk),
    .sys_rst_n (sys_rst_n),
    .ch_en_req (ch_en_req),
    .ch_rst_req(ch_rst_req),
    .ch_idle   (ch_idle),
    .testmode  (testmode),
    .ch_clk_en (ch_clk_en),
    .ch_rst_n  (ch_rst_n),
    .ch_rdy    (ch_rdy),
    .ch_busy   (ch_busy)
  );

  per_multi_rst_clk_seq #(
    .CH_NUM                  (1),
    .CLK_ON_AFTER_RST_RELEASE(0)
  ) u_dut_nodly (
    .i_clk     (i_clk),
    .sys_rst_n (sys_rst_n),
    .ch_en_req (z_en_req),
    .ch_rst_req(z_rst_req),
    .ch_idle   (z_idle),
    .testmode  (1'b0),
    .ch_clk_en (z_clk_en),
    .ch_rst_n  (z_rst_n),
    .ch_rdy    (z_rdy),
    .ch_busy   (z_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_rst_n, input logic [3:0] e_clk_en,
                           input logic [3:0] e_rdy, input logic [3:0] e_busy);
    check({tag, ".rst_n"},  32'(ch_rst_n),  32'(e_rst_n));
    check({tag, ".clk_en"}, 32'(ch_clk_en), 32'(e_clk_en));
    check({tag, ".rdy"},    32'(ch_rdy),    32'(e_rdy));
    check({tag, ".busy"},   32'(ch_busy),   32'(e_busy));
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    ch_en_req  = 4'hF;
    ch_rst_req = 4'h0;
    ch_idle    = 4'h0;
    testmode   = 1'b0;
    z_en_req   = 1'b1;
    z_rst_req  = 1'b0;
    z_idle     = 1'b0;
    #3;
    check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    check("reset.nodly_rst_n", 32'(z_rst_n), 32'h0);

    // testmode while held in HOLD
    testmode = 1'b1;
    #1;
    check("tm_on.clk_en", 32'(ch_clk_en), 32'hF);
    check("tm_on.rst_n",  32'(ch_rst_n),  32'h0);
    testmode = 1'b0;
    #1;
    check("tm_off.clk_en", 32'(ch_clk_en), 32'h0);

    // release: REL for 2 cycles, RUN from cycle 3
    tick();
    sys_rst_n = 1'b1;
    tick();
    check_all("rel_c1", 4'hF, 4'h0, 4'h0, 4'hF);
    check("nodly_c1.rst_n",  32'(z_rst_n),  32'h1);
    check("nodly_c1.clk_en", 32'(z_clk_en), 32'h1);
    check("nodly_c1.rdy",    32'(z_rdy),    32'h1);
    tick();
    check_all("rel_c2", 4'hF, 4'h0, 4'h0, 4'hF);
    tick();
    check_all("run_c3", 4'hF, 4'hF, 4'hF, 4'h0);

    // one-cycle reset pulse on channel 1
    ch_rst_req = 4'b0010;
    tick();
    ch_rst_req = 4'b0000;
    check_all("ch1_assert1", 4'b1101, 4'hF, 4'b1101, 4'b0010);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check_all($sformatf("ch1_assert%0d", i), 4'b1101, 4'hF, 4'b1101, 4'b0010);
    end
    tick();
    check_all("ch1_hold", 4'b1101, 4'b1101, 4'b1101, 4'b0000);
    tick();
    check_all("ch1_rel1", 4'hF, 4'b1101, 4'b1101, 4'b0010);
    tick();
    check_all("ch1_rel2", 4'hF, 4'b1101, 4'b1101, 4'b0010);
    tick();
    check_all("ch1_run", 4'hF, 4'hF, 4'hF, 4'h0);

    // channel 0: reset, then re-request during REL; request held 2 cycles
    ch_rst_req = 4'b0001;
    tick();
    ch_rst_req = 4'b0000;
    repeat (3) tick();
    tick();
    check_all("ch0_hold", 4'b1110, 4'b1110, 4'b1110, 4'b0000);
    tick();
    check_all("ch0_rel1", 4'hF, 4'b1110, 4'b1110, 4'b0001);
    ch_rst_req = 4'b0001;
    tick();
    check_all("ch0_rel_abort", 4'b1110, 4'hF, 4'b1110, 4'b0001);
    tick();
    ch_rst_req = 4'b0000;
    tick();
    tick();
    check_all("ch0_assert4", 4'b1110, 4'hF, 4'b1110, 4'b0001);
    tick();
    check_all("ch0_hold2", 4'b1110, 4'b1110, 4'b1110, 4'b0000);
    repeat (2) tick();
    check_all("ch0_rel2", 4'hF, 4'b1110, 4'b1110, 4'b0001);
    tick();
    check_all("ch0_run", 4'hF, 4'hF, 4'hF, 4'h0);

    // system reset in the middle of ASSERT
    ch_rst_req = 4'hF;
    z_rst_req  = 1'b1;
    tick();
    tick();
    check_all("all_assert", 4'h0, 4'hF, 4'h0, 4'hF);
    sys_rst_n  = 1'b0;
    ch_rst_req = 4'h0;
    z_rst_req  = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    check("async_rst.nodly_rdy", 32'(z_rdy), 32'h0);
    #2;
    sys_rst_n = 1'b1;
    tick();
    check_all("rerel_c1", 4'hF, 4'h0, 4'h0, 4'hF);
    repeat (2) tick();
    check_all("rerun_c3", 4'hF, 4'hF, 4'hF, 4'h0);

    // clock request has one cycle of latency
    ch_en_req = 4'b1011;
    tick();
    check("en_off.clk_en", 32'(ch_clk_en), 32'hB);
    ch_en_req = 4'hF;
    tick();
    check("en_on.clk_en", 32'(ch_clk_en), 32'hF);

    // idle auto-gating on channel 0
    ch_idle = 4'b0001;
    repeat (16) tick();
    check("idle16.clk_en", 32'(ch_clk_en), 32'hF);
    tick();
`ifdef PER_AUTO_IDLE_GATE_EN
    check("idle17.clk_en", 32'(ch_clk_en), 32'hE);
`else
    check("idle17.clk_en", 32'(ch_clk_en), 32'hF);
`endif
    check("idle17.rdy", 32'(ch_rdy), 32'hF);
    ch_idle = 4'b0000;
    tick();
    check("wake.clk_en", 32'(ch_clk_en), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
